// File: rtl/spi_fifo_ctrl.sv
`timescale 1ns/1ps
// spi_fifo_ctrl
// Buffered byte-stream front end for the SPI path. CPU-written bytes are
// queued in a TX FIFO. One shifter transfer is launched per byte, and each
// received byte is collected in an RX FIFO. The block also owns the SPI
// chip-select bit and a level interrupt.
//
// Ports
//   clk, rst         system clock, synchronous active-low reset
//   cs, we, addr     CPU bus access qualifier, write enable, register select
//   din / dout       CPU write data / read data (combinational mux)
//   rdy              stall (low-true), always 1
//   irq              level interrupt (high-true)
//   sh_start/sh_txd  launch pulse and byte to the downstream shifter
//   sh_busy          shifter busy (status only, unused for sequencing)
//   sh_done/sh_rxd   completion pulse and received byte from the shifter
//   spi_cs0          SPI chip select (CTRL bit 0)
module spi_fifo_ctrl #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       irq,
  output logic       sh_start,
  output logic [7:0] sh_txd,
  input  logic       sh_busy,
  input  logic       sh_done,
  input  logic [7:0] sh_rxd,
  output logic       spi_cs0
);

  localparam int          DEPTH      = 1 << AW;
  localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [7:0]  tx_mem [DEPTH];
  logic [7:0]  rx_mem [DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0] tx_count, rx_count;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic [3:0]  ctrl;
  logic        tx_ovf;
  logic        bus_wr, bus_rd;
  logic        flush, tx_push, tx_ovf_set, ovf_clr, ctrl_wr, rx_pop;
  logic        launch, rx_push, busy, rx_discard;
  logic [7:0]  status, rx_head;
  logic        unused_ok;

  // Pointers carry one extra bit so that full and empty stay distinct across wrap.
  assign tx_count   = tx_wp - tx_rp;
  assign rx_count   = rx_wp - rx_rp;
  assign tx_empty   = (tx_wp == tx_rp);
  assign rx_empty   = (rx_wp == rx_rp);
  assign tx_full    = (tx_count == FULL_COUNT);
  assign rx_full    = (rx_count == FULL_COUNT);
  assign rx_discard = ctrl[3];
  assign bus_wr     = cs & we;
  assign bus_rd     = cs & ~we;
  assign busy       = (state != ST_IDLE) | ~tx_empty;
  assign status     = {1'b0, ctrl[0], tx_ovf, rx_full, ~rx_empty, tx_empty, tx_full, busy};
  assign rx_head    = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];
  assign rdy        = 1'b1;
  assign spi_cs0    = ctrl[0];
  assign irq        = (ctrl[1] & ~rx_empty) | (ctrl[2] & tx_empty & (state == ST_IDLE));
  assign unused_ok  = sh_busy;

  // Bus decode: register-side effects of the current CPU access.
  always_comb begin
    flush      = 1'b0;
    tx_push    = 1'b0;
    tx_ovf_set = 1'b0;
    ovf_clr    = 1'b0;
    ctrl_wr    = 1'b0;
    rx_pop     = 1'b0;
    if (bus_wr) begin
      case (addr)
        2'd1: begin
          // Fullness is judged before any same-cycle FSM pop.
          if (tx_full) begin
            tx_ovf_set = 1'b1;
          end else begin
            tx_push = 1'b1;
          end
        end
        2'd2: begin
          ovf_clr = din[0];
          flush   = din[1];
        end
        2'd3:    ctrl_wr = 1'b1;
        default: ctrl_wr = 1'b0;
      endcase
    end else if (bus_rd) begin
      rx_pop = (addr == 2'd1) & ~rx_empty;
    end else begin
      rx_pop = 1'b0;
    end
  end

  // Transfer FSM: next state, TX pop/launch and RX push.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    rx_push   = 1'b0;
    case (state)
      ST_IDLE: begin
        // A full RX holds the stream unless received bytes are being discarded.
        if (~tx_empty & (~rx_full | rx_discard) & ~flush) begin
          launch    = 1'b1;
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (sh_done) begin
          // The full guard covers discard being cleared while a byte is in flight.
          rx_push   = ~rx_discard & ~flush & (~rx_full | rx_pop);
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control state, FIFO pointers and shifter launch registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tx_wp    <= '0;
      tx_rp    <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      ctrl     <= 4'h1;
      tx_ovf   <= 1'b0;
      sh_start <= 1'b0;
      sh_txd   <= 8'h00;
    end else begin
      state    <= state_nxt;
      sh_start <= launch;
      if (launch) begin
        sh_txd <= tx_mem[tx_rp[AW-1:0]];
      end
      if (tx_ovf_set) begin
        tx_ovf <= 1'b1;
      end else if (ovf_clr) begin
        tx_ovf <= 1'b0;
      end
      if (ctrl_wr) begin
        ctrl <= din[3:0];
      end
      if (flush) begin
        tx_wp <= '0;
        tx_rp <= '0;
        rx_wp <= '0;
        rx_rp <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + PTR_ONE;
        if (launch)  tx_rp <= tx_rp + PTR_ONE;
        if (rx_push) rx_wp <= rx_wp + PTR_ONE;
        if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
      end
    end
  end

  // FIFO storage; contents are don't-care until pointers make them visible.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= din;
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= sh_rxd;
  end

  // CPU read data mux.
  always_comb begin
    dout = 8'h00;
    case (addr)
      2'd0:    dout = status;
      2'd1:    dout = rx_head;
      2'd2:    dout = 8'(rx_count);
      2'd3:    dout = {4'h0, ctrl};
      default: dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_spi_fifo_ctrl.sv
`timescale 1ns/1ps
// Directed bench for spi_fifo_ctrl (AW=4, DEPTH=16) with a stub shifter that
// answers each sh_start with the inverted byte about 16 clocks later.
module tb_spi_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, cs, we;
  logic [1:0] addr;
  logic [7:0] din, dout;
  logic       rdy, irq, sh_start, sh_busy, sh_done, spi_cs0;
  logic [7:0] sh_txd, sh_rxd;

  logic       stub_done = 1'b0;
  logic [7:0] stub_rxd = 8'h00;
  logic [7:0] stub_lat = 8'h00;
  logic [4:0] stub_cnt = 5'd0;
  logic       stub_busy = 1'b0;
  logic       extra_done;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign sh_busy = stub_busy;
  assign sh_done = stub_done | extra_done;
  assign sh_rxd  = extra_done ? 8'h77 : stub_rxd;

  spi_fifo_ctrl #(.AW(4)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .rdy(rdy), .irq(irq), .sh_start(sh_start), .sh_txd(sh_txd),
    .sh_busy(sh_busy), .sh_done(sh_done), .sh_rxd(sh_rxd), .spi_cs0(spi_cs0)
  );

  // Stub shifter: latch on sh_start, pulse done with the inverted byte later.
  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (!rst) begin
      stub_cnt  <= 5'd0;
      stub_busy <= 1'b0;
    end else if (sh_start) begin
      stub_cnt  <= 5'd16;
      stub_busy <= 1'b1;
      stub_lat  <= sh_txd;
    end else if (stub_cnt == 5'd1) begin
      stub_cnt  <= 5'd0;
      stub_busy <= 1'b0;
      stub_done <= 1'b1;
      stub_rxd  <= ~stub_lat;
    end else if (stub_cnt != 5'd0) begin
      stub_cnt <= stub_cnt - 5'd1;
    end
  end

  // Event counters for launch and completion pulses.
  always @(posedge clk) begin
    if (sh_start) start_cnt <= start_cnt + 1;
    if (sh_done)  done_cnt  <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    #1 d = dout;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic read_chk(input logic [1:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] v;
    bus_read(a, v);
    chk(tag, v, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_status(input logic [7:0] mask, input logic [7:0] val,
                             input int budget, input string tag);
    logic [7:0] s;
    logic ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      bus_read(2'd0, s);
      if ((s & mask) == val) ok = 1'b1;
    end
    chk(tag, 8'(ok), 8'd1);
  endtask

  task automatic wait_dones(input int target, input int budget, input string tag);
    for (int n = 0; n < budget && done_cnt < target; n++) @(negedge clk);
    chk(tag, 8'(done_cnt >= target), 8'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    int s0, d0;
    rst = 1'b0; cs = 1'b0; we = 1'b0; addr = 2'd0; din = 8'h00; extra_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state and empty-RX read.
    read_chk(2'd0, 8'h44, "rst_status");
    read_chk(2'd3, 8'h01, "rst_ctrl");
    chk("rst_cs0", 8'(spi_cs0), 8'd1);
    chk("rst_irq", 8'(irq), 8'd0);
    chk("rst_txd", sh_txd, 8'h00);
    read_chk(2'd1, 8'h00, "rx_empty_read");
    read_chk(2'd2, 8'h00, "rst_rxcnt");
    bus_write(2'd0, 8'hFF);
    read_chk(2'd0, 8'h44, "status_write_ignored");

    // Single byte: sh_start is high in the cycle after the write edge.
    d0 = done_cnt;
    bus_write(2'd1, 8'hA5);
    chk("start_at_e", 8'(sh_start), 8'd0);
    @(negedge clk);
    chk("start_at_e1", 8'(sh_start), 8'd1);
    chk("txd_a5", sh_txd, 8'hA5);
    @(negedge clk);
    chk("start_pulse_end", 8'(sh_start), 8'd0);
    wait_dones(d0 + 1, 60, "single_done");
    read_chk(2'd2, 8'h01, "single_rxcnt1");
    read_chk(2'd1, 8'h5A, "single_rx");
    read_chk(2'd2, 8'h00, "single_rxcnt0");
    read_chk(2'd0, 8'h44, "single_idle");
    chk("txd_held", sh_txd, 8'hA5);

    // Burst of 20: byte 0 leaves TX on the second write edge, so bytes
    // 0x00..0x10 fit and 0x11..0x13 are dropped.
    for (int i = 0; i < 20; i++) bus_write(2'd1, 8'(i));
    bus_read(2'd0, s);
    chk("burst_ovf_full", s & 8'h22, 8'h22);
    for (int i = 0; i < 17; i++) begin
      wait_status(8'h08, 8'h08, 100, "burst_rx_avail");
      read_chk(2'd1, ~8'(i), "burst_rx");
    end
    wait_status(8'h01, 8'h00, 100, "burst_idle");
    read_chk(2'd2, 8'h00, "burst_no_extra");
    read_chk(2'd0, 8'h64, "burst_ovf_hold");
    bus_write(2'd2, 8'h01);
    read_chk(2'd0, 8'h44, "ovf_clear");

    // RX backpressure: 18 spaced writes, RX fills at 16 with 2 left in TX.
    for (int i = 0; i < 18; i++) begin
      bus_write(2'd1, 8'h20 + 8'(i));
      idle(20);
    end
    wait_status(8'h10, 8'h10, 200, "bp_rx_full");
    idle(40);
    read_chk(2'd2, 8'd16, "bp_rxcnt16");
    read_chk(2'd0, 8'h59, "bp_status_stall");
    s0 = start_cnt;
    read_chk(2'd1, 8'hDF, "bp_rx0");
    idle(40);
    chk("bp_one_start", 8'(start_cnt - s0), 8'd1);
    read_chk(2'd2, 8'd16, "bp_rxcnt_again");
    read_chk(2'd0, 8'h59, "bp_status_one_left");
    read_chk(2'd1, 8'hDE, "bp_rx1");
    idle(40);
    read_chk(2'd0, 8'h5C, "bp_tx_drained");
    for (int i = 2; i < 18; i++) read_chk(2'd1, ~(8'h20 + 8'(i)), "bp_drain");
    read_chk(2'd2, 8'h00, "bp_rxcnt0");

    // Discard mode: transfers run, nothing lands in RX.
    bus_write(2'd3, 8'h08);
    s0 = start_cnt; d0 = done_cnt;
    for (int i = 0; i < 4; i++) bus_write(2'd1, 8'h40 + 8'(i));
    wait_dones(d0 + 4, 200, "disc_done4");
    chk("disc_starts", 8'(start_cnt - s0), 8'd4);
    read_chk(2'd2, 8'h00, "disc_rxcnt");

    // Flush during WAIT with 3 queued: only the in-flight byte completes.
    s0 = start_cnt; d0 = done_cnt;
    for (int i = 0; i < 4; i++) bus_write(2'd1, 8'h50 + 8'(i));
    bus_write(2'd2, 8'h02);
    idle(60);
    chk("flush_one_done", 8'(done_cnt - d0), 8'd1);
    chk("flush_one_start", 8'(start_cnt - s0), 8'd1);
    read_chk(2'd0, 8'h04, "flush_status");

    // Flush empties RX; the in-flight byte then lands in the empty RX.
    bus_write(2'd3, 8'h01);
    d0 = done_cnt;
    bus_write(2'd1, 8'h61);
    wait_dones(d0 + 1, 60, "flushrx_first");
    read_chk(2'd2, 8'h01, "flushrx_cnt1");
    d0 = done_cnt;
    bus_write(2'd1, 8'h62);
    idle(2);
    bus_write(2'd2, 8'h02);
    read_chk(2'd2, 8'h00, "flushrx_emptied");
    wait_dones(d0 + 1, 60, "flushrx_inflight");
    read_chk(2'd2, 8'h01, "flushrx_cnt_after");
    read_chk(2'd1, 8'h9D, "flushrx_byte");

    // Interrupts and chip select.
    bus_write(2'd3, 8'h02);
    chk("irq_rx_idle", 8'(irq), 8'd0);
    chk("cs0_low", 8'(spi_cs0), 8'd0);
    d0 = done_cnt;
    bus_write(2'd1, 8'h3C);
    wait_dones(d0 + 1, 60, "irq_rx_done");
    chk("irq_rx_set", 8'(irq), 8'd1);
    read_chk(2'd1, 8'hC3, "irq_rx_byte");
    chk("irq_rx_clr", 8'(irq), 8'd0);
    bus_write(2'd3, 8'h04);
    chk("irq_tx_empty", 8'(irq), 8'd1);
    d0 = done_cnt;
    bus_write(2'd1, 8'h11);
    chk("irq_tx_busy", 8'(irq), 8'd0);
    wait_dones(d0 + 1, 60, "irq_tx_done");
    chk("irq_tx_again", 8'(irq), 8'd1);
    read_chk(2'd1, 8'hEE, "irq_tx_rx");
    bus_write(2'd3, 8'h01);
    chk("cs0_high", 8'(spi_cs0), 8'd1);
    cs = 1'b1; we = 1'b1; addr = 2'd3; din = 8'h00;
    #1 chk("cs0_before_edge", 8'(spi_cs0), 8'd1);
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    chk("cs0_after_edge", 8'(spi_cs0), 8'd0);

    // Reset during WAIT, then a stray sh_done while idle.
    bus_write(2'd3, 8'h06);
    bus_write(2'd1, 8'h81);
    bus_write(2'd1, 8'h82);
    idle(3);
    chk("pre_rst_txd", sh_txd, 8'h81);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_start", 8'(sh_start), 8'd0);
    chk("mid_rst_txd", sh_txd, 8'h00);
    chk("mid_rst_cs0", 8'(spi_cs0), 8'd1);
    chk("mid_rst_irq", 8'(irq), 8'd0);
    read_chk(2'd0, 8'h44, "mid_rst_status");
    read_chk(2'd3, 8'h01, "mid_rst_ctrl");
    s0 = start_cnt;
    idle(30);
    chk("mid_rst_no_start", 8'(start_cnt - s0), 8'd0);
    extra_done = 1'b1;
    @(negedge clk);
    extra_done = 1'b0;
    read_chk(2'd2, 8'h00, "late_done_ignored");
    read_chk(2'd0, 8'h44, "late_done_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
